// File: rtl/fp_norm_pkg.sv
// Shared widths, constants and state encoding for the floating-point result normalizer.
package fp_norm_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} norm_state_t;
endpackage

// File: rtl/fp_result_normalizer_pack.sv
// Combinational packer: internal {sign, exp, fraction, zero} to an IEEE-754 single word.
module fp_pack
  import fp_norm_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-2:0] frac,
  input  logic             zero,
  output logic [31:0]      word
);

  // A zero or flushed result keeps its sign so -0 survives the packing.
  always_comb begin
    if (zero) word = {sign, {(EXP_W+MAN_W-1){1'b0}}};
    else      word = {sign, exp, frac};
  end

endmodule

// File: rtl/fp_result_normalizer.sv
// Iterative post-add normalizer: one left shift per cycle, then pack and hold on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for an internal-format result, in_ready high
// NORM  | shifting mantissa left until normalized, zero, Inf/NaN or underflow
// PACK  | registering the IEEE-754 word and flags
// HOLD  | presenting the result until out_ready
module fp_result_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] out_data,
  output logic                   out_zero,
  output logic                   out_underflow,
  output logic                   busy
);
  import fp_norm_pkg::*;

  norm_state_t             state_q, state_d;
  logic                    sign_q;
  logic [EXP_W-1:0]        exp_q;
  logic [MAN_W-1:0]        man_q;
  logic                    zero_q;
  logic                    unf_q;
  logic [EXP_W+MAN_W-1:0]  pack_word;

  logic norm_done;
  assign norm_done = (exp_q == EXP_INF) || (man_q == '0) || man_q[MAN_W-1] ||
                     (exp_q <= EXP_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = NORM;
      NORM:    if (norm_done) state_d = PACK;
      PACK:                   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q        <= 1'b0;
      exp_q         <= '0;
      man_q         <= '0;
      zero_q        <= 1'b0;
      unf_q         <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= in_data[EXP_W+MAN_W];
          exp_q  <= in_data[EXP_W+MAN_W-1 -: EXP_W];
          man_q  <= in_data[MAN_W-1:0];
          zero_q <= 1'b0;
          unf_q  <= 1'b0;
        end
        NORM: begin
          // Priority matters: Inf/NaN and exact zero are never shifted or flushed.
          if (exp_q == EXP_INF) begin
          end else if (man_q == '0) begin
            zero_q <= 1'b1;
          end else if (man_q[MAN_W-1]) begin
          end else if (exp_q <= EXP_W'(1)) begin
            zero_q <= 1'b1;
            unf_q  <= 1'b1;
          end else begin
            man_q <= man_q << 1;
            exp_q <= exp_q - 1'b1;
          end
        end
        PACK: begin
          out_data      <= pack_word;
          out_zero      <= zero_q;
          out_underflow <= unf_q;
          out_valid     <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  fp_pack u_pack (
    .sign (sign_q),
    .exp  (exp_q),
    .frac (man_q[MAN_W-2:0]),
    .zero (zero_q),
    .word (pack_word)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule
